local_mem_arbiter: RTL and testbench
====================================

# local_mem_arbiter

Shares one port of the dual-port local memory between NUM_REQ requesters (e.g. instruction fetch, load/store unit, debug/DMA) using round-robin arbitration. Grants at most one access per cycle, drives the memory port, and routes the one-cycle-latency read data back to the requester that issued the read. Sits between the requester units and one port of the byte-enable BRAM wrapper.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- ADDR_W, 30: word-address width
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  request present, per requester
- req_addr  in  NUM_REQ×ADDR_W  word address
- req_be  in  NUM_REQ×4  byte enables; 4'b0000 = read, nonzero = write
- req_wdata  in  NUM_REQ×32  write data
- req_ready  out  NUM_REQ  one-hot grant; request accepted this cycle
- rsp_valid  out  NUM_REQ  one-hot read-data valid
- rsp_data  out  32  read data, shared by all requesters
- mem_en  out  1  memory port enable
- mem_addr  out  ADDR_W  memory word address
- mem_be  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_be = 0

## Operation
- Round-robin pointer last_gnt (log2 NUM_REQ bits) holds the index of the last granted requester. The search starts at last_gnt+1 and wraps modulo NUM_REQ. The first requester found with req_valid set is granted.
- Grant is combinational from req_valid and last_gnt. req_ready is set only for the winner.
- mem_en = |req_valid. mem_addr, mem_be, and mem_wdata are muxed from the winner. When nothing is valid, the mux holds index last_gnt and mem_en = 0.
- On grant, last_gnt ← winner index.
- Read grant (be = 0): set rd_pend ← 1 and rd_id ← winner. The next cycle, rsp_valid[rd_id] = 1 and rsp_data = mem_rdata.
- Write grant: no response; the write completes in the BRAM at the clock edge.
- There is no response backpressure. Requesters must accept rsp_valid in the cycle it is asserted.
- Back-to-back accesses are allowed every cycle. Read and write ordering between requesters follows grant order.
- While rst is asserted, req_ready = 0 and mem_en = 0.
- A single requester holding req_valid continuously is granted every cycle.
- If a requester drops req_valid before it is granted, that request is lost. This is legal; no state is kept.

## Timing
- Reset values:
  - last_gnt = NUM_REQ-1, so requester 0 has first priority.
  - rd_pend = 0 and rd_id = 0.
  - rsp_valid = 0, rsp_data = 0.
  - req_ready = 0, mem_en = 0.
- Grant latency: 0 cycles, combinational req_valid → req_ready in the same cycle.
- Read latency: rsp_valid is asserted exactly 1 cycle after req_ready for a read. The macro below changes this to 2.
- Reset asserted mid-operation: a pending read is dropped and rsp_valid is forced to 0 asynchronously. A write granted in the cycle reset asserts is not guaranteed.
- Simultaneous requests when all NUM_REQ are valid: grants rotate 0,1,…,NUM_REQ-1,0 with no idle cycles.

## Configuration
- LOCAL_MEM_ARB_RSP_REG_EN defined:
  - Adds a register stage on rsp_data and rsp_valid after the BRAM output. rsp_data is registered from mem_rdata.
  - Read latency becomes 2 cycles and timing from the BRAM output is improved.
  - rd_pend and rd_id are pipelined one extra stage. The extra stage resets to 0.
- Undefined: 1-cycle read latency, and rsp_data is driven combinationally from mem_rdata.

## Structure
- Shared package local_mem_pkg holds:
  - the requester-index typedef
  - the local_mem_req_t struct (addr, be, wdata)
  - the localparam LOCAL_MEM_READ_LATENCY
- One sub-module, rr_arbiter (parameter NUM_REQ):
  - inputs: request vector and update enable
  - outputs: one-hot grant and encoded index
  - owns last_gnt
- The top level owns the request mux, read-tag pipeline, and response demux.

## Test plan
- Reset priority: after reset, req_valid=2'b11 with requester 0 read at addr 0x10 → req_ready=2'b01. The next grant cycle gives 2'b10.
- Write then read: requester 1 writes be=4'b1111, wdata=0xDEADBEEF to addr 0x4, then reads 0x4 → rsp_valid=2'b10 one cycle after the read grant, rsp_data=0xDEADBEEF.
- Partial write: preload 0x11223344 at 0x8, write be=4'b0010 with wdata=0x0000AA00, then read → rsp_data=0x1122AA44.
- Fairness: NUM_REQ=4, all valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Each requester's reads are returned to its own rsp_valid bit.
- Reset mid-read: assert rst in the cycle after a read grant → rsp_valid stays 0. After release, last_gnt=NUM_REQ-1.
- Macro on: repeat the write-then-read scenario with LOCAL_MEM_ARB_RSP_REG_EN → rsp_valid 2 cycles after the grant, same data. Back-to-back reads by requesters 0 then 1 return in order.

Source files
------------

// File: rtl/local_mem_arbiter_pkg.sv
// Shared types and constants for the local memory arbiter.
// Read latency follows LOCAL_MEM_ARB_RSP_REG_EN (1 cycle when undefined, 2 when defined).
package local_mem_pkg;

  localparam int LOCAL_MEM_MAX_REQ = 8;
  localparam int LOCAL_MEM_ADDR_W  = 30;
  localparam int LOCAL_MEM_DATA_W  = 32;

`ifdef LOCAL_MEM_ARB_RSP_REG_EN
  localparam int LOCAL_MEM_READ_LATENCY = 2;
`else
  localparam int LOCAL_MEM_READ_LATENCY = 1;
`endif

  typedef logic [$clog2(LOCAL_MEM_MAX_REQ)-1:0] req_idx_t;

  typedef struct packed {
    logic [LOCAL_MEM_ADDR_W-1:0] addr;
    logic [3:0]                  be;
    logic [LOCAL_MEM_DATA_W-1:0] wdata;
  } local_mem_req_t;

endpackage

// File: rtl/local_mem_arbiter_if.sv
// Requester-side and memory-side bus of the local memory arbiter.
// master = requesters plus BRAM, slave = arbiter.
interface local_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 30
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][3:0]        req_be;
  logic [NUM_REQ-1:0][31:0]       req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [31:0]                    rsp_data;
  logic                           mem_en;
  logic [ADDR_W-1:0]              mem_addr;
  logic [3:0]                     mem_be;
  logic [31:0]                    mem_wdata;
  logic [31:0]                    mem_rdata;

  modport master (
    output req_valid, req_addr, req_be, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_be, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/local_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_upd_en,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] r_last_gnt;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // With no request the index stays on the last winner so the mux output is stable.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_last_gnt;
    w_cand  = '0;
    o_gnt   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_gnt) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found) o_gnt[w_idx] = 1'b1;
  end

  assign o_idx = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= IDX_W'(NUM_REQ - 1);
    end else if (i_upd_en && w_found) begin
      r_last_gnt <= w_idx;
    end
  end

endmodule

// File: rtl/local_mem_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters and routes read data back by tag.
// Optional LOCAL_MEM_ARB_RSP_REG_EN adds a response register stage (2-cycle reads).
module local_mem_arbiter
  import local_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 30
) (
  input  logic                clk,
  input  logic                rst,
  local_mem_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic                 w_any;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_idx;
  local_mem_req_t       w_req [NUM_REQ];
  local_mem_req_t       w_sel;
  logic                 w_rd_grant;
  logic                 w_rsp_vld;
  req_idx_t             w_rsp_id;
  logic                 r_rd_vld_p0;
  req_idx_t             r_rd_id_p0;

  assign w_any = |bus.req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.req_valid),
    .i_upd_en (w_any),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i].addr  = LOCAL_MEM_ADDR_W'(bus.req_addr[i]);
      w_req[i].be    = bus.req_be[i];
      w_req[i].wdata = bus.req_wdata[i];
    end
  end

  assign w_sel         = w_req[w_idx];
  assign bus.req_ready = rst ? '0 : w_gnt;
  assign bus.mem_en    = w_any & ~rst;
  assign bus.mem_addr  = ADDR_W'(w_sel.addr);
  assign bus.mem_be    = w_sel.be;
  assign bus.mem_wdata = w_sel.wdata;
  assign w_rd_grant    = bus.mem_en && (w_sel.be == 4'b0000);

  // p0: read tag, aligned with the BRAM output cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld_p0 <= 1'b0;
      r_rd_id_p0  <= '0;
    end else begin
      r_rd_vld_p0 <= w_rd_grant;
      if (w_rd_grant) r_rd_id_p0 <= req_idx_t'(w_idx);
    end
  end

`ifdef LOCAL_MEM_ARB_RSP_REG_EN
  logic        r_rd_vld_p1;
  req_idx_t    r_rd_id_p1;
  logic [31:0] r_rsp_data_p1;

  // p1: registered response, cuts the path from the BRAM output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld_p1   <= 1'b0;
      r_rd_id_p1    <= '0;
      r_rsp_data_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= r_rd_vld_p0;
      r_rd_id_p1  <= r_rd_id_p0;
      if (r_rd_vld_p0) r_rsp_data_p1 <= bus.mem_rdata;
    end
  end

  assign w_rsp_vld    = r_rd_vld_p1;
  assign w_rsp_id     = r_rd_id_p1;
  assign bus.rsp_data = r_rsp_data_p1;
`else
  assign w_rsp_vld    = r_rd_vld_p0;
  assign w_rsp_id     = r_rd_id_p0;
  assign bus.rsp_data = r_rd_vld_p0 ? bus.mem_rdata : '0;
`endif

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = w_rsp_vld && (w_rsp_id == req_idx_t'(i));
    end
  end

endmodule

// File: tb/tb_local_mem_arbiter.sv
// Bench for local_mem_arbiter: BRAM model, queue-based reference model, directed and random stimulus.
module tb_local_mem_arbiter;
  import local_mem_pkg::*;

  localparam int NR  = 4;
  localparam int AW  = 30;
  localparam int LAT = LOCAL_MEM_READ_LATENCY;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  local_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

  local_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple byte-enable BRAM with one-cycle read latency
  logic [31:0] bram [256];
  logic [31:0] bram_q;
  assign bus.mem_rdata = bram_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_be == 4'b0000) begin
        bram_q <= bram[bus.mem_addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) bram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec-level round robin, grant-ordered memory, response queue
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t           q[$];
  logic [31:0]    mmem [256];
  int             m_last;
  int             m_cyc = 0;
  int             m_win;
  int             m_c;
  logic [NR-1:0]  m_ready;
  logic [NR-1:0]  m_rv;
  logic [31:0]    m_rd;
  logic [7:0]     m_a;

  always @(negedge clk) begin
    m_cyc++;
    if (rst) begin
      m_last = NR - 1;
      q.delete();
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_mem_en",    32'(bus.mem_en),    32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data",  bus.rsp_data,       32'h0);
    end else begin
      m_rv = '0;
      m_rd = '0;
      if (q.size() > 0 && q[0].due == m_cyc) begin
        m_rv[q[0].id] = 1'b1;
        m_rd = q[0].data;
        void'(q.pop_front());
      end
      chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      if (m_rv != '0) chk("model_rsp_data", bus.rsp_data, m_rd);

      m_win = -1;
      for (int k = 1; k <= NR; k++) begin
        m_c = (m_last + k) % NR;
        if (m_win < 0 && bus.req_valid[m_c]) m_win = m_c;
      end
      m_ready = '0;
      if (m_win >= 0) m_ready[m_win] = 1'b1;
      chk("model_req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("model_mem_en", 32'(bus.mem_en), 32'(m_win >= 0));

      if (m_win >= 0) begin
        chk("model_mem_addr",  32'(bus.mem_addr),  32'(bus.req_addr[m_win]));
        chk("model_mem_be",    32'(bus.mem_be),    32'(bus.req_be[m_win]));
        chk("model_mem_wdata", bus.mem_wdata,      bus.req_wdata[m_win]);
        m_a = bus.req_addr[m_win][7:0];
        if (bus.req_be[m_win] == 4'b0000) begin
          q.push_back('{m_cyc + LAT, m_win, mmem[m_a]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (bus.req_be[m_win][b]) mmem[m_a][8*b +: 8] = bus.req_wdata[m_win][8*b +: 8];
        end
        m_last = m_win;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.req_valid = '0;
  endtask

  task automatic set_req(input int i, input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i]  = a;
    bus.req_be[i]    = be;
    bus.req_wdata[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram[i] = '0;
      mmem[i] = '0;
    end
    bram_q        = '0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    set_req(0, 30'h10, 4'h0, 32'h0);
    set_req(1, 30'h20, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_lit", 32'(bus.req_ready), 32'h0);
    chk("reset_mem_en_lit", 32'(bus.mem_en), 32'h0);

    // Reset priority
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("prio_first", 32'(bus.req_ready), 32'b0001);
    step();
    @(negedge clk);
    chk("prio_second", 32'(bus.req_ready), 32'b0010);

    // Write then read by requester 1
    step(); clr(); set_req(1, 30'h4, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_grant", 32'(bus.req_ready), 32'b0010);
    step(); clr(); set_req(1, 30'h4, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd_grant", 32'(bus.req_ready), 32'b0010);
    step(); clr();
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("wr_rd_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("wr_rd_data", bus.rsp_data, 32'hDEADBEEF);

    // Partial write
    step(); clr(); set_req(0, 30'h8, 4'hF, 32'h11223344);
    step(); clr(); set_req(0, 30'h8, 4'b0010, 32'h0000AA00);
    step(); clr(); set_req(0, 30'h8, 4'h0, 32'h0);
    step(); clr();
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("partial_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("partial_data", bus.rsp_data, 32'h1122AA44);

    // Fairness: park pointer on 3, all write, then all read
    step(); clr(); set_req(3, 30'h30, 4'h0, 32'h0);
    step(); clr();
    for (int i = 0; i < NR; i++) set_req(i, 30'(32'h40 + i), 4'hF, 32'hA0 + 32'(i));
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      chk("fair_wr_grant", 32'(bus.req_ready), 32'(1) << i);
      step();
    end
    for (int i = 0; i < NR; i++) set_req(i, 30'(32'h40 + i), 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fair_rd_grant", 32'(bus.req_ready), 32'(1) << (i % NR));
      if (i >= LAT) begin
        chk("fair_rsp_valid", 32'(bus.rsp_valid), 32'(1) << ((i - LAT) % NR));
        chk("fair_rsp_data", bus.rsp_data, 32'hA0 + 32'((i - LAT) % NR));
      end
      step();
    end
    clr();

    // Single requester held valid is granted every cycle
    for (int i = 0; i < 3; i++) begin
      set_req(2, 30'(32'h50 + i), 4'hF, 32'h5500 + 32'(i));
      @(negedge clk);
      chk("hold_grant", 32'(bus.req_ready), 32'b0100);
      step();
    end
    clr();
    repeat (LAT + 1) step();

    // Reset in the cycle after a read grant
    set_req(2, 30'h41, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_mid_grant", 32'(bus.req_ready), 32'b0100);
    step(); clr(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'h0);
    step(); rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 30'(32'h40 + i), 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_release_prio", 32'(bus.req_ready), 32'b0001);
    step(); clr();
    repeat (LAT + 1) step();

    // Random traffic
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 99) < 45);
        bus.req_addr[i]  = 30'($urandom_range(0, 15));
        bus.req_be[i]    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        bus.req_wdata[i] = $urandom;
      end
    end
    step(); clr(); rst = 1'b0;
    repeat (LAT + 3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
